// File: rtl/led_scan_sequencer_if.sv
// Signal bundle between the LED scan sequencer and the panel drivers / host.
// The master side is the sequencer; the slave side is whoever consumes the
// driver strobes and raises the enable/swap/brightness requests.
// Optional: define LED_SCAN_FRAME_COUNT_EN to add the 16-bit frame_count.
interface led_scan_sequencer_if #(
  parameter int N_ROWS    = 16,
  parameter int PWM_BITS  = 8,
  parameter int SHIFT_LEN = 64
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int BIT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;

  logic                enable;
  logic                swap_req;
  logic                bright_req;
  logic                serial_clk;
  logic                latch_enable;
  logic                output_enable_n;
  logic [N_ROWS-1:0]   row_select_n;
  logic [ROW_W-1:0]    active_row_addr;
  logic [PWM_BITS-1:0] pwm_time;
  logic [BIT_W-1:0]    bit_index;
  logic                load_pixels;
  logic                load_brightness;
  logic                shift;
  logic                buf_sel;
  logic                swap_ack;
  logic                frame_start;
`ifdef LED_SCAN_FRAME_COUNT_EN
  logic [15:0]         frame_count;

  modport master (
    input  enable, swap_req, bright_req,
    output serial_clk, latch_enable, output_enable_n, row_select_n,
           active_row_addr, pwm_time, bit_index, load_pixels,
           load_brightness, shift, buf_sel, swap_ack, frame_start,
           frame_count
  );

  modport slave (
    output enable, swap_req, bright_req,
    input  serial_clk, latch_enable, output_enable_n, row_select_n,
           active_row_addr, pwm_time, bit_index, load_pixels,
           load_brightness, shift, buf_sel, swap_ack, frame_start,
           frame_count
  );
`else
  modport master (
    input  enable, swap_req, bright_req,
    output serial_clk, latch_enable, output_enable_n, row_select_n,
           active_row_addr, pwm_time, bit_index, load_pixels,
           load_brightness, shift, buf_sel, swap_ack, frame_start
  );

  modport slave (
    output enable, swap_req, bright_req,
    input  serial_clk, latch_enable, output_enable_n, row_select_n,
           active_row_addr, pwm_time, bit_index, load_pixels,
           load_brightness, shift, buf_sel, swap_ack, frame_start
  );
`endif
endinterface

// File: rtl/led_scan_sequencer.sv
// Timing and scan generator for multiplexed LED panels.
// Each PWM step is LOAD, SHIFT_LEN two-clock serial bits, then LATCH. After
// 2^PWM_BITS steps the row is blanked for BLANK_CYCLES clocks and the row
// address advances. When the row wraps, the frame boundary handles a pending
// buffer swap, an optional brightness-load phase, and the run/stop decision.
// Optional: define LED_SCAN_FRAME_COUNT_EN to add a 16-bit frame counter.
module led_scan_sequencer #(
  parameter int N_ROWS       = 16,
  parameter int PWM_BITS     = 8,
  parameter int SHIFT_LEN    = 64,
  parameter int BLANK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  led_scan_sequencer_if.master bus
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int BIT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [BIT_W-1:0]    BIT_LAST   = BIT_W'(SHIFT_LEN - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(N_ROWS - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = {PWM_BITS{1'b1}};
  localparam logic [BLK_W-1:0]    BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [N_ROWS-1:0]   ROW_ONE    = N_ROWS'(1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    BLANK,
    BRIGHT_LOAD,
    BRIGHT_SHIFT_LO,
    BRIGHT_SHIFT_HI,
    BRIGHT_LATCH
  } state_t;

  state_t              state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [BLK_W-1:0]    blank_q, blank_d;
  logic                buf_q, buf_d;
  logic                swap_ack_q, swap_ack_d;
  logic                frame_start_q, frame_start_d;

  logic                serial_clk_c;
  logic                latch_c;
  logic                oe_n_c;
  logic [N_ROWS-1:0]   row_sel_n_c;
  logic                load_pixels_c;
  logic                load_bright_c;
  logic                shift_c;

  // Next-state and counter update logic; frame boundary ordering is swap, then brightness, then enable.
  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    pwm_d         = pwm_q;
    row_d         = row_q;
    blank_d       = blank_q;
    buf_d         = buf_q;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d       = LOAD;
          frame_start_d = 1'b1;
        end
      end
      LOAD:     state_d = SHIFT_LO;
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (bit_q == BIT_LAST) begin
          state_d = LATCH;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = SHIFT_LO;
        end
      end
      LATCH: begin
        bit_d   = '0;
        pwm_d   = pwm_q + PWM_BITS'(1);
        state_d = (pwm_q == PWM_LAST) ? BLANK : LOAD;
      end
      BLANK: begin
        if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          row_d   = row_q + ROW_W'(1);
          if (row_q == ROW_LAST) begin
            if (bus.swap_req) begin
              buf_d      = ~buf_q;
              swap_ack_d = 1'b1;
            end
            if (bus.bright_req) begin
              state_d = BRIGHT_LOAD;
            end else if (bus.enable) begin
              state_d       = LOAD;
              frame_start_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = LOAD;
          end
        end else begin
          blank_d = blank_q + BLK_W'(1);
        end
      end
      BRIGHT_LOAD:     state_d = BRIGHT_SHIFT_LO;
      BRIGHT_SHIFT_LO: state_d = BRIGHT_SHIFT_HI;
      BRIGHT_SHIFT_HI: begin
        if (bit_q == BIT_LAST) begin
          state_d = BRIGHT_LATCH;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = BRIGHT_SHIFT_LO;
        end
      end
      BRIGHT_LATCH: begin
        bit_d = '0;
        if (bus.enable) begin
          state_d       = LOAD;
          frame_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any scan immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_q         <= '0;
      pwm_q         <= '0;
      row_q         <= '0;
      blank_q       <= '0;
      buf_q         <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      pwm_q         <= pwm_d;
      row_q         <= row_d;
      blank_q       <= blank_d;
      buf_q         <= buf_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Driver strobes decoded from the current state; panel is lit only during the scan steps.
  always_comb begin
    serial_clk_c  = 1'b0;
    latch_c       = 1'b0;
    oe_n_c        = 1'b1;
    row_sel_n_c   = '1;
    load_pixels_c = 1'b0;
    load_bright_c = 1'b0;
    shift_c       = 1'b0;
    case (state_q)
      LOAD: begin
        load_pixels_c = 1'b1;
        oe_n_c        = 1'b0;
        row_sel_n_c   = ~(ROW_ONE << row_q);
      end
      SHIFT_LO: begin
        shift_c     = 1'b1;
        oe_n_c      = 1'b0;
        row_sel_n_c = ~(ROW_ONE << row_q);
      end
      SHIFT_HI: begin
        serial_clk_c = 1'b1;
        oe_n_c       = 1'b0;
        row_sel_n_c  = ~(ROW_ONE << row_q);
      end
      LATCH: begin
        latch_c     = 1'b1;
        oe_n_c      = 1'b0;
        row_sel_n_c = ~(ROW_ONE << row_q);
      end
      BRIGHT_LOAD:     load_bright_c = 1'b1;
      BRIGHT_SHIFT_LO: shift_c       = 1'b1;
      BRIGHT_SHIFT_HI: serial_clk_c  = 1'b1;
      BRIGHT_LATCH:    latch_c       = 1'b1;
      default: begin
        oe_n_c = 1'b1;
      end
    endcase
  end

`ifdef LED_SCAN_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Counts frame starts, advancing on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign bus.frame_count = frame_count_q;
`endif

  assign bus.serial_clk      = serial_clk_c;
  assign bus.latch_enable    = latch_c;
  assign bus.output_enable_n = oe_n_c;
  assign bus.row_select_n    = row_sel_n_c;
  assign bus.active_row_addr = row_q;
  assign bus.pwm_time        = pwm_q;
  assign bus.bit_index       = bit_q;
  assign bus.load_pixels     = load_pixels_c;
  assign bus.load_brightness = load_bright_c;
  assign bus.shift           = shift_c;
  assign bus.buf_sel         = buf_q;
  assign bus.swap_ack        = swap_ack_q;
  assign bus.frame_start     = frame_start_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Scoreboard bench for led_scan_sequencer with a small panel (4 rows,
// 2 PWM bits, 4 serial bits, 2 blank clocks). Step = 10 clocks, row = 42,
// frame = 168. Stimulus pushes the hand-computed event stream; a monitor
// turns DUT pulses into events and pops/compares them.
module tb_led_scan_sequencer;
  localparam int N_ROWS       = 4;
  localparam int PWM_BITS     = 2;
  localparam int SHIFT_LEN    = 4;
  localparam int BLANK_CYCLES = 2;

  localparam int K_SWAP   = 0;
  localparam int K_ROW    = 1;
  localparam int K_BRIGHT = 2;
  localparam int K_LATCH  = 3;
  localparam int K_FRAME  = 4;

  typedef struct {
    int kind;
    int cyc;
    int d0;
    int d1;
    int d2;
  } ev_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;
  ev_t  exp_q[$];

  led_scan_sequencer_if #(
    .N_ROWS(N_ROWS), .PWM_BITS(PWM_BITS), .SHIFT_LEN(SHIFT_LEN)
  ) bus ();

  led_scan_sequencer #(
    .N_ROWS(N_ROWS), .PWM_BITS(PWM_BITS), .SHIFT_LEN(SHIFT_LEN),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Free-running clock and an absolute cycle counter used as event timestamps.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      K_SWAP:   return "swap_ack";
      K_ROW:    return "row_change";
      K_BRIGHT: return "load_brightness";
      K_LATCH:  return "latch";
      K_FRAME:  return "frame_start";
      default:  return "unknown";
    endcase
  endfunction

  function automatic void pushEv(input int kind, input int c, input int d0, input int d1, input int d2);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.d0   = d0;
    e.d1   = d1;
    e.d2   = d2;
    exp_q.push_back(e);
  endfunction

  // frame_start data: buf_sel, row_select_n, pwm_time
  function automatic void pushFrameStart(input int c, input int bufSel);
    pushEv(K_FRAME, c, bufSel, 4'b1110, 0);
  endfunction

  // Latches of a frame starting at s, plus row changes into rows 1..3.
  // latch data: shifts seen, serial_clk highs seen, {row_select_n, pwm_time, output_enable_n}
  function automatic void pushScan(input int s);
    for (int r = 0; r < N_ROWS; r++) begin
      if (r > 0) pushEv(K_ROW, s + 42 * r, r, 2, 0);
      for (int p = 0; p < 4; p++) begin
        pushEv(K_LATCH, s + 9 + 42 * r + 10 * p, 4, 4,
               ((4'hF & ~(1 << r)) << 3) | (p << 1));
      end
    end
  endfunction

  // Events at a frame boundary whose first post-boundary cycle is b.
  function automatic void pushBoundary(input int b, input bit doSwap, input int newBuf,
                                       input bit bright, input bit nextEn);
    if (doSwap) pushEv(K_SWAP, b, newBuf, 0, 0);
    pushEv(K_ROW, b, 0, 2, (bright || !nextEn) ? 1 : 0);
    if (bright) begin
      pushEv(K_BRIGHT, b, 1, 4'hF, 0);
      pushEv(K_LATCH, b + 9, 4, 4, (4'hF << 3) | 1);
    end
  endfunction

  task automatic observe(input int kind, input int d0, input int d1, input int d2);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected %s at cycle %0d: got (%0d,%0d,%0d), required no event",
               kindName(kind), cyc, d0, d1, d2);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.d0 != d0 || e.d1 != d1 || e.d2 != d2) begin
        fails++;
        $display("[TB] FAIL %s: got %s@%0d (%0d,%0d,%0d), required %s@%0d (%0d,%0d,%0d)",
                 kindName(e.kind), kindName(kind), cyc, d0, d1, d2,
                 kindName(e.kind), e.cyc, e.d0, e.d1, e.d2);
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit sw, input bit br);
    bus.enable     = en;
    bus.swap_req   = sw;
    bus.bright_req = br;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic checkQuiet(input string tag, input int bufSel);
    checkOutput({tag, " serial_clk"}, int'(bus.serial_clk), 0);
    checkOutput({tag, " latch_enable"}, int'(bus.latch_enable), 0);
    checkOutput({tag, " output_enable_n"}, int'(bus.output_enable_n), 1);
    checkOutput({tag, " row_select_n"}, int'(bus.row_select_n), 4'hF);
    checkOutput({tag, " active_row_addr"}, int'(bus.active_row_addr), 0);
    checkOutput({tag, " pwm_time"}, int'(bus.pwm_time), 0);
    checkOutput({tag, " bit_index"}, int'(bus.bit_index), 0);
    checkOutput({tag, " pulses"}, int'({bus.load_pixels, bus.load_brightness, bus.shift,
                                        bus.swap_ack, bus.frame_start}), 0);
    checkOutput({tag, " buf_sel"}, int'(bus.buf_sel), bufSel);
  endtask

  // Monitor: samples on the falling edge and converts DUT pulses into scoreboard events.
  initial begin
    int prevRow  = 0;
    int dark     = 0;
    int shiftCnt = 0;
    int sclkCnt  = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.swap_ack) observe(K_SWAP, int'(bus.buf_sel), 0, 0);
        if (int'(bus.active_row_addr) != prevRow)
          observe(K_ROW, int'(bus.active_row_addr), dark, int'(bus.output_enable_n));
        if (bus.load_brightness) begin
          observe(K_BRIGHT, int'(bus.output_enable_n), int'(bus.row_select_n), 0);
          shiftCnt = 0;
          sclkCnt  = 0;
        end
        if (bus.shift) shiftCnt++;
        if (bus.serial_clk) sclkCnt++;
        if (bus.latch_enable) begin
          observe(K_LATCH, shiftCnt, sclkCnt,
                  int'({bus.row_select_n, bus.pwm_time, bus.output_enable_n}));
          shiftCnt = 0;
          sclkCnt  = 0;
        end
        if (bus.frame_start) begin
          observe(K_FRAME, int'(bus.buf_sel), int'(bus.row_select_n), int'(bus.pwm_time));
          shiftCnt = 0;
          sclkCnt  = 0;
        end
        dark    = (bus.output_enable_n && bus.row_select_n == 4'hF) ? dark + 1 : 0;
        prevRow = int'(bus.active_row_addr);
      end
    end
  end

  // Directed stimulus: scan with mid-frame swap, brightness phase, combined swap+brightness,
  // enable drop, then an asynchronous reset in the middle of a shift.
  initial begin
    int base;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #2;
    checkQuiet("reset", 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    base = cyc;
    pushFrameStart(base + 1, 0);
    pushScan(base + 1);
    pushBoundary(base + 169, 1'b1, 1, 1'b0, 1'b1);
    pushFrameStart(base + 169, 1);
    pushScan(base + 169);
    applyStimulus(1'b1, 1'b0, 1'b0);

    waitUntil(base + 50);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(base + 100);
    checkOutput("buf_sel held mid-frame", int'(bus.buf_sel), 0);
    waitUntil(base + 175);
    applyStimulus(1'b1, 1'b0, 1'b0);

    waitUntil(base + 200);
    pushBoundary(base + 337, 1'b0, 0, 1'b1, 1'b1);
    pushFrameStart(base + 347, 1);
    pushScan(base + 347);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitUntil(base + 340);
    applyStimulus(1'b1, 1'b0, 1'b0);

    waitUntil(base + 400);
    pushBoundary(base + 515, 1'b1, 0, 1'b1, 1'b1);
    pushFrameStart(base + 525, 0);
    pushScan(base + 525);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitUntil(base + 520);
    applyStimulus(1'b1, 1'b0, 1'b0);

    waitUntil(base + 600);
    pushBoundary(base + 693, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    waitUntil(base + 710);
    checkQuiet("idle after enable drop", 0);
`ifdef LED_SCAN_FRAME_COUNT_EN
    checkOutput("frame_count after 4 frames", int'(bus.frame_count), 4);
`endif

    base = cyc;
    pushFrameStart(base + 1, 0);
    pushScan(base + 1);
    pushBoundary(base + 169, 1'b1, 1, 1'b0, 1'b1);
    pushFrameStart(base + 169, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitUntil(base + 172);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(base + 173);
    checkOutput("mid-shift serial_clk", int'(bus.serial_clk), 1);
    checkOutput("mid-shift output_enable_n", int'(bus.output_enable_n), 0);
    checkOutput("mid-shift bit_index", int'(bus.bit_index), 1);
    checkOutput("mid-shift buf_sel", int'(bus.buf_sel), 1);
`ifdef LED_SCAN_FRAME_COUNT_EN
    checkOutput("frame_count before reset", int'(bus.frame_count), 6);
`endif
    #2 reset_n = 1'b0;
    #1;
    checkQuiet("async reset mid-shift", 0);
`ifdef LED_SCAN_FRAME_COUNT_EN
    checkOutput("frame_count after reset", int'(bus.frame_count), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkQuiet("idle after reset", 0);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missing %s: got no event, required at cycle %0d (%0d,%0d,%0d)",
               kindName(e.kind), e.cyc, e.d0, e.d1, e.d2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
Parametrised timing and scan generator for multiplexed LED panels. It supersedes the fixed 19-bit counter and control-ROM scheme used in the first-generation controller. It drives the serial clock, latch, output enable and row selects, and issues load/shift strobes to the per-panel drivers. Over the earlier design it adds:
- a runtime enable
- a frame-boundary double-buffer swap handshake
- an on-request brightness-load phase
- programmable row-change blanking

Parameters:
N_ROWS, 16, scanned rows; power of two, 2..64
PWM_BITS, 8, PWM resolution; 2^PWM_BITS display steps per row
SHIFT_LEN, 64, serial bits shifted per step
BLANK_CYCLES, 4, clocks with outputs dark around each row change; minimum 1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run scan; sampled only at frame boundary
swap_req  in  1  level request to swap display buffers
bright_req  in  1  level request to run brightness-load phase
serial_clk  out  1  driver shift clock
latch_enable  out  1  driver latch strobe
output_enable_n  out  1  driver output enable, active low
row_select_n  out  N_ROWS  one-cold row drive
active_row_addr  out  log2(N_ROWS)  row currently shifted/displayed
pwm_time  out  PWM_BITS  current PWM step
bit_index  out  log2(SHIFT_LEN)  current serial bit position
load_pixels  out  1  one-cycle pulse: drivers load pixel words for next step
load_brightness  out  1  one-cycle pulse: drivers load brightness words
shift  out  1  one-cycle pulse per serial bit
buf_sel  out  1  display buffer the drivers read
swap_ack  out  1  one-cycle pulse when buf_sel toggles
frame_start  out  1  one-cycle pulse on the first LOAD of a frame

Behaviour:
Reset values:
- Outputs: serial_clk=0, latch_enable=0, output_enable_n=1, row_select_n=all ones; all counters 0; buf_sel=0; all pulses 0.
- State: IDLE.
- Reset mid-operation aborts immediately to these values.

FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, BLANK, BRIGHT_LOAD, BRIGHT_SHIFT_LO, BRIGHT_SHIFT_HI, BRIGHT_LATCH.

IDLE:
- If enable=1: next state LOAD, frame_start pulses.

LOAD:
- 1 clock; load_pixels=1.
- Next state SHIFT_LO.

SHIFT_LO:
- shift=1, serial_clk=0.

SHIFT_HI:
- serial_clk=1.
- If bit_index=SHIFT_LEN-1: next state LATCH; otherwise bit_index++ and next state SHIFT_LO.
- One bit takes 2 clocks.

LATCH:
- 1 clock; latch_enable=1; bit_index cleared.
- If pwm_time != max: pwm_time++ and next state LOAD.
- If pwm_time wraps to 0: next state BLANK.

BLANK:
- Lasts BLANK_CYCLES clocks; output_enable_n=1 and row_select_n=all ones.
- active_row_addr increments on the last BLANK clock.
- If the row wraps to 0, the frame ends (see frame-boundary rules below).
- Otherwise next state LOAD.

Outside IDLE and BLANK:
- output_enable_n=0.
- row_select_n has a single 0 at bit active_row_addr.

Step and row timing:
- Step period: 2*SHIFT_LEN+2 clocks (LOAD + shift bits + LATCH).
- Row period: 2^PWM_BITS step periods + BLANK_CYCLES.

Frame boundary (after the last BLANK of the last row), applied in this order in the same clock:
1. Swap: if swap_req=1, buf_sel toggles and swap_ack pulses for 1 clock. Mid-frame swap_req has no effect until the boundary. Requesters hold swap_req until they see swap_ack.
2. Brightness: if bright_req=1, next state BRIGHT_LOAD.
   - BRIGHT_LOAD: load_brightness=1 for 1 clock.
   - BRIGHT_SHIFT_LO/BRIGHT_SHIFT_HI: shift SHIFT_LEN bits, same timing as SHIFT_LO/SHIFT_HI.
   - BRIGHT_LATCH: 1 clock, latch_enable=1.
   - Throughout: output_enable_n=1 and row_select_n=all ones.
   - Then continue as step 3.
3. Enable: if enable=1, next state LOAD with frame_start pulse; otherwise next state IDLE.

Simultaneous events:
- swap_req and bright_req both set at the boundary: the swap happens first, then the brightness phase.
- Deasserting enable mid-frame completes the frame; it never truncates one.

Counter rules:
- All counters are unsigned and wrap at their field width.
- No other counter is compared against a full-width value.

Optional Feature:
Macro: LED_SCAN_FRAME_COUNT_EN.
- Defined: adds output port frame_count [15:0]. Resets to 0, increments by 1 on each frame_start pulse, wraps 65535→0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, N_ROWS=4, PWM_BITS=2, SHIFT_LEN=4, BLANK_CYCLES=2 -> frame_start 1 clock after enable; 4 shift pulses and 4 serial_clk highs per step; latch every 10 clocks; row period 42 clocks; row_select_n steps 1110→1101→1011→0111.
- During BLANK -> output_enable_n=1 and row_select_n=1111 for exactly 2 clocks; active_row_addr changes on the last of them.
- swap_req raised mid-frame -> no toggle until frame end; then buf_sel 0→1 with a single swap_ack pulse; no further toggle while swap_req stays held and is handled per boundary.
- bright_req=1 at boundary -> load_brightness pulse, 4 shift pulses, latch, output_enable_n=1 throughout; next frame_start follows BRIGHT_LATCH by 1 clock.
- enable dropped mid-frame -> frame completes to last row, then IDLE with output_enable_n=1; reset_n pulsed mid-SHIFT -> all outputs at reset values asynchronously.
- With LED_SCAN_FRAME_COUNT_EN, preload by running 65536 frames (small params) -> frame_count wraps 65535→0.
